// File: rtl/fader_ctrl_pkg.sv
// fader_ctrl_pkg: shared states, result record and constants for the fader scheduler
package fader_ctrl_pkg;
    localparam int DROP_CNT_W = 8;
    localparam int STAT_LAT_W = 16;
    localparam int MIN_PERIOD = 2;
    localparam int RES_T_W = 25;
    localparam int RES_D_W = 16;

    typedef enum logic [1:0] {IDLE, ARMED, START, WAIT_DV} state_t;

    typedef struct packed {
        logic [RES_T_W-1:0] t_index;
        logic [RES_D_W-1:0] zc_real;
        logic [RES_D_W-1:0] zc_imag;
    } result_t;
endpackage

// File: rtl/fader_ctrl_timer.sv
// fader_ctrl_timer: period down-counter emitting a single-cycle tick every eff_period enabled cycles
module fader_ctrl_timer import fader_ctrl_pkg::*; #(
    parameter int PERIOD_W = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic [PERIOD_W-1:0] period,
    output logic                tick
);
    logic [PERIOD_W-1:0] cnt;
    logic [PERIOD_W-1:0] reload;

    always_comb begin
        reload = (period < PERIOD_W'(MIN_PERIOD)) ? PERIOD_W'(MIN_PERIOD - 1) : period - 1'b1;
        tick = enable && cnt == '0;
    end

    // reload samples period, so a new period lands at the next reload
    always_ff @(posedge clk or posedge reset)
        if (reset)
            cnt <= '0;
        else
            cnt <= (!enable || tick) ? reload : cnt - 1'b1;
endmodule

// File: rtl/fader_ctrl.sv
// fader_ctrl: fader start sequencer with result register, drop/timeout tracking; stats under FADER_CTRL_STATS_EN
module fader_ctrl import fader_ctrl_pkg::*; #(
    parameter int T_W      = RES_T_W,
    parameter int D_W      = RES_D_W,
    parameter int PERIOD_W = 16,
    parameter int TIMEOUT  = 1023
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [PERIOD_W-1:0]   period,
    input  logic                  load_t,
    input  logic [T_W-1:0]        t_init,
    input  logic                  clear_err,
    output logic                  fader_start,
    output logic [T_W-1:0]        fader_t_index,
    input  logic                  fader_dv,
    input  logic [D_W-1:0]        fader_zc_real,
    input  logic [D_W-1:0]        fader_zc_imag,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [T_W-1:0]        m_t_index,
    output logic [D_W-1:0]        m_zc_real,
    output logic [D_W-1:0]        m_zc_imag,
    output logic                  busy,
    output logic                  timeout_err,
    output logic [DROP_CNT_W-1:0] drop_cnt,
    output logic [31:0]           stat_done,
    output logic [STAT_LAT_W-1:0] stat_max_lat
);
    state_t                state, state_nx;
    logic                  tick, capture, timeout, out_free, drop;
    logic [T_W-1:0]        t_index;
    logic [STAT_LAT_W-1:0] lat;
    result_t               res;

    fader_ctrl_timer #(.PERIOD_W(PERIOD_W)) u_timer (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .period (period),
        .tick   (tick)
    );

    always_comb begin
        capture  = state == WAIT_DV && fader_dv;
        timeout  = state == WAIT_DV && !fader_dv && lat == STAT_LAT_W'(TIMEOUT);
        out_free = !m_valid || m_ready;
        drop     = tick && (state == START || state == WAIT_DV || (state == ARMED && !out_free));
        state_nx = state;
        case (state)
            IDLE:    state_nx = enable ? ARMED : IDLE;
            ARMED:   state_nx = !enable ? IDLE : (tick && out_free) ? START : ARMED;
            START:   state_nx = WAIT_DV;
            WAIT_DV: state_nx = (capture || timeout) ? (enable ? ARMED : IDLE) : WAIT_DV;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            state       <= IDLE;
            t_index     <= '0;
            lat         <= '0;
            res         <= '0;
            m_valid     <= 1'b0;
            timeout_err <= 1'b0;
            drop_cnt    <= '0;
        end else begin
            state <= state_nx;
            if (load_t && (state == IDLE || state == ARMED))
                t_index <= t_init;
            else if (capture)
                t_index <= t_index + 1'b1;
            // first WAIT_DV cycle sees lat=1
            lat <= (state == WAIT_DV) ? lat + 1'b1 : STAT_LAT_W'(1);
            if (capture)
                res <= '{t_index, fader_zc_real, fader_zc_imag};
            m_valid     <= capture || (m_valid && !m_ready);
            timeout_err <= !clear_err && (timeout_err || timeout);
            drop_cnt    <= clear_err ? '0 : (drop && drop_cnt != '1) ? drop_cnt + 1'b1 : drop_cnt;
        end

    assign fader_start   = state == START;
    assign busy          = state == START || state == WAIT_DV;
    assign fader_t_index = t_index;
    assign m_t_index     = res.t_index;
    assign m_zc_real     = res.zc_real;
    assign m_zc_imag     = res.zc_imag;

`ifdef FADER_CTRL_STATS_EN
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            stat_done    <= '0;
            stat_max_lat <= '0;
        end else if (clear_err) begin
            stat_done    <= '0;
            stat_max_lat <= '0;
        end else if (capture) begin
            stat_done    <= stat_done + 1'b1;
            stat_max_lat <= (lat > stat_max_lat) ? lat : stat_max_lat;
        end
`else
    assign stat_done    = '0;
    assign stat_max_lat = '0;
`endif
endmodule

// File: tb/tb_fader_ctrl.sv
// tb_fader_ctrl: randomized scoreboard bench for fader_ctrl against a cycle-level behavioural model
module tb_fader_ctrl;
    localparam int T_W = 25, D_W = 16, PERIOD_W = 16, TIMEOUT = 1023;

    logic clk = 1'b0, reset, enable, load_t, clear_err, fader_start, fader_dv, m_valid, m_ready, busy, timeout_err;
    logic [PERIOD_W-1:0] period;
    logic [T_W-1:0] t_init, fader_t_index, m_t_index;
    logic [D_W-1:0] fader_zc_real, fader_zc_imag, m_zc_real, m_zc_imag;
    logic [7:0] drop_cnt;
    logic [31:0] stat_done;
    logic [15:0] stat_max_lat;

    int total = 0, bad = 0;

    always #5 clk = ~clk;

    fader_ctrl dut (
        .clk(clk), .reset(reset), .enable(enable), .period(period), .load_t(load_t), .t_init(t_init),
        .clear_err(clear_err), .fader_start(fader_start), .fader_t_index(fader_t_index), .fader_dv(fader_dv),
        .fader_zc_real(fader_zc_real), .fader_zc_imag(fader_zc_imag), .m_valid(m_valid), .m_ready(m_ready),
        .m_t_index(m_t_index), .m_zc_real(m_zc_real), .m_zc_imag(m_zc_imag), .busy(busy),
        .timeout_err(timeout_err), .drop_cnt(drop_cnt), .stat_done(stat_done), .stat_max_lat(stat_max_lat)
    );

    typedef struct {
        logic [T_W-1:0] t;
        logic [D_W-1:0] re;
        logic [D_W-1:0] im;
    } res_t;

    res_t sb[$];
    logic [T_W-1:0] acc_log[$];
    bit outst = 0, start_now = 0, mfull = 0, terr = 0;
    bit tick, cap, tmo, acc, start_nx;
    int drops = 0, age = 0, en_cnt = 0, eff, done = 0, maxlat = 0;
    int cyc = 0, last_st = 0, iv_exp = 0;
    logic [T_W-1:0] ref_t = '0;
    bit dead[7];
    res_t r;

    int fl_fixed = 300, pend = 0;
    bit fl_rnd = 0, spur = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cchk(input int i, input string name, input logic [63:0] act, input logic [63:0] exp);
        if (!dead[i]) begin
            chk(name, act, exp);
            if (act !== exp) dead[i] = 1;
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int w = 0;
        enable = 1'b0;
        while (outst && w < 3000) begin
            cycles(1);
            w++;
        end
        chk("drain_busy", 64'(busy), 64'(0));
        cycles(3);
    endtask

    task automatic chk_stats(input string tag);
`ifdef FADER_CTRL_STATS_EN
        chk({tag, "_stat_done"}, 64'(stat_done), 64'(done));
        chk({tag, "_stat_max_lat"}, 64'(stat_max_lat), 64'(maxlat));
`else
        chk({tag, "_stat_done"}, 64'(stat_done), 64'(0));
        chk({tag, "_stat_max_lat"}, 64'(stat_max_lat), 64'(0));
`endif
    endtask

    // fader core stand-in: dv a chosen number of cycles after each start
    initial begin
        fader_dv = 1'b0;
        fader_zc_real = '0;
        fader_zc_imag = '0;
        forever begin
            @(posedge clk);
            #1;
            fader_dv = 1'b0;
            if (reset) pend = 0;
            else begin
                if (pend > 0) begin
                    pend--;
                    if (pend == 0) begin
                        fader_dv = 1'b1;
                        fader_zc_real = D_W'($urandom);
                        fader_zc_imag = D_W'($urandom);
                    end
                end else if (spur && !outst && $urandom_range(0, 15) == 0) begin
                    fader_dv = 1'b1;
                    fader_zc_real = D_W'($urandom);
                end
                if (fader_start) pend = fl_rnd ? int'($urandom_range(1, 30)) : fl_fixed;
            end
        end
    end

    // reference model and monitor: compare current state, then advance by the spec rules
    always @(negedge clk) begin
        cyc++;
        if (reset) begin
            outst = 0; start_now = 0; mfull = 0; terr = 0; drops = 0; age = 0; en_cnt = 0;
            ref_t = '0; done = 0; maxlat = 0;
            sb.delete();
        end else begin
            cchk(0, "fader_start", 64'(fader_start), 64'(start_now));
            cchk(1, "busy", 64'(busy), 64'(outst));
            cchk(2, "m_valid", 64'(m_valid), 64'(mfull));
            cchk(3, "timeout_err", 64'(timeout_err), 64'(terr));
            cchk(4, "drop_cnt", 64'(drop_cnt), 64'(drops));
            cchk(5, "fader_t_index", 64'(fader_t_index), 64'(ref_t));
            if (mfull && sb.size() > 0)
                cchk(6, "m_hold", 64'({m_t_index, m_zc_real, m_zc_imag}), 64'({sb[0].t, sb[0].re, sb[0].im}));
            if (fader_start) begin
                if (iv_exp != 0 && last_st != 0) chk("start_interval", 64'(cyc - last_st), 64'(iv_exp));
                last_st = cyc;
            end
            eff = (period < 2) ? 2 : int'(period);
            tick = 0;
            if (enable) begin
                en_cnt++;
                tick = (en_cnt % eff) == 0;
            end else en_cnt = 0;
            if (start_now) age = 0;
            else if (outst) age++;
            cap = outst && !start_now && fader_dv;
            tmo = outst && !start_now && !fader_dv && age == TIMEOUT;
            acc = mfull && m_ready;
            if (acc && sb.size() > 0) begin
                r = sb.pop_front();
                chk("m_t_index", 64'(m_t_index), 64'(r.t));
                chk("m_zc_real", 64'(m_zc_real), 64'(r.re));
                chk("m_zc_imag", 64'(m_zc_imag), 64'(r.im));
                acc_log.push_back(m_t_index);
            end
            if (cap) begin
                sb.push_back('{ref_t, fader_zc_real, fader_zc_imag});
                done++;
                if (age > maxlat) maxlat = age;
            end
            start_nx = 0;
            if (tick) begin
                if (outst || (mfull && !m_ready)) drops = (drops < 255) ? drops + 1 : 255;
                else start_nx = 1;
            end
            if (load_t && !outst) ref_t = t_init;
            else if (cap) ref_t = ref_t + 1'b1;
            outst = (outst && !cap && !tmo) || start_nx;
            start_now = start_nx;
            mfull = cap || (mfull && !m_ready);
            terr = !clear_err && (terr || tmo);
            if (clear_err) begin
                drops = 0; done = 0; maxlat = 0;
            end
        end
    end

    initial begin
        reset = 1'b1; enable = 1'b0; load_t = 1'b0; clear_err = 1'b0; m_ready = 1'b1;
        period = 16'd1024; t_init = '0;
        #2;
        chk("rst_start", 64'(fader_start), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_m_valid", 64'(m_valid), 64'(0));
        chk("rst_t_index", 64'(fader_t_index), 64'(0));
        chk("rst_terr", 64'(timeout_err), 64'(0));
        chk("rst_drop", 64'(drop_cnt), 64'(0));
        chk("rst_m_data", 64'({m_t_index, m_zc_real, m_zc_imag}), 64'(0));
        @(posedge clk); @(posedge clk); #3 reset = 1'b0;
        cycles(3);

        iv_exp = 1024; last_st = 0; enable = 1'b1;
        cycles(5 * 1024 + 400);
        iv_exp = 0;
        chk("p2_drop", 64'(drop_cnt), 64'(0));
        chk("p2_t_index", 64'(fader_t_index), 64'(5));

        m_ready = 1'b0;
        cycles(3 * 1024);
        m_ready = 1'b1;
        cycles(1100);
        chk("p3_drop", 64'(drop_cnt), 64'(2));
        chk("p3_t_index", 64'(fader_t_index), 64'(7));

        drain();
        fl_fixed = 0; period = 16'd1030;
        cycles(2);
        enable = 1'b1;
        cycles(2100);
        chk("p4_terr", 64'(timeout_err), 64'(1));
        chk("p4_t_index", 64'(fader_t_index), 64'(7));
        clear_err = 1'b1; cycles(1); clear_err = 1'b0;
        chk("p4_terr_clr", 64'(timeout_err), 64'(0));
        drain();
        fl_fixed = 10;

        t_init = 25'h1FFFFFF; load_t = 1'b1; period = 16'd64;
        cycles(1);
        load_t = 1'b0;
        cycles(2);
        acc_log.delete();
        enable = 1'b1;
        cycles(64 * 2 + 30);
        chk("p5_count", 64'(acc_log.size()), 64'(2));
        if (acc_log.size() >= 2) begin
            chk("p5_first", 64'(acc_log[0]), 64'(25'h1FFFFFF));
            chk("p5_wrap", 64'(acc_log[1]), 64'(0));
        end
        chk_stats("p5");

        drain();
        period = 16'd0; fl_fixed = 5;
        cycles(2);
        enable = 1'b1;
        cycles(1000);
        chk("p6_sat", 64'(drop_cnt), 64'(255));
        clear_err = 1'b1; cycles(1); clear_err = 1'b0;
        chk("p6_clr", 64'(drop_cnt), 64'(0));
        cycles(20);
        drain();

        fl_rnd = 1; spur = 1;
        for (int b = 0; b < 4; b++) begin
            period = PERIOD_W'($urandom_range(0, 40));
            cycles(2);
            enable = 1'b1;
            repeat (800) begin
                cycles(1);
                m_ready = ($urandom_range(0, 3) != 0);
                load_t = ($urandom_range(0, 49) == 0);
                t_init = T_W'($urandom);
                clear_err = ($urandom_range(0, 99) == 0);
            end
            load_t = 1'b0; clear_err = 1'b0; m_ready = 1'b1;
            drain();
            chk_stats("p7");
        end
        fl_rnd = 0; spur = 0;

        period = 16'd50; fl_fixed = 20;
        cycles(2);
        enable = 1'b1;
        for (int w = 0; w < 200 && !(outst && !start_now); w++) cycles(1);
        chk("p8_wait_dv", 64'(busy && !fader_start), 64'(1));
        @(posedge clk);
        #3 reset = 1'b1; enable = 1'b0;
        #1;
        chk("p8_busy", 64'(busy), 64'(0));
        chk("p8_m_valid", 64'(m_valid), 64'(0));
        chk("p8_t_index", 64'(fader_t_index), 64'(0));
        chk("p8_m_data", 64'({m_t_index, m_zc_real, m_zc_imag}), 64'(0));
        chk("p8_drop", 64'(drop_cnt), 64'(0));
        chk("p8_stats", 64'({stat_done, stat_max_lat}), 64'(0));
        cycles(2);
        @(posedge clk);
        #3 reset = 1'b0;
        cycles(20);
        enable = 1'b1;
        cycles(130);
        chk("p8_resume_t", 64'(fader_t_index), 64'(2));
        chk_stats("p8");
        enable = 1'b0;
        cycles(50);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fader_ctrl.md
Name: fader_ctrl

Overview:
- Scheduler/sequencer for the fader HLS core: issues periodic single-cycle start pulses, owns the t_index sequence and waits for dv_out per start.
- Captures each result (Zc_real/Zc_imag tagged with its t_index) into a valid/ready output register for downstream consumers.
- Detects dropped ticks and core timeouts.
- Sits between system control registers and the fader instance.

Parameters:
- T_W, 25, t_index width.
- D_W, 16, Zc sample width.
- PERIOD_W, 16, width of the tick period register.
- TIMEOUT, 1023, maximum cycles from start to dv before abort.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous active-high reset.
- enable  in  1  run scheduling; sampled every cycle.
- period  in  PERIOD_W  cycles between ticks; values 0 and 1 are treated as 2.
- load_t  in  1  single-cycle pulse; loads t_init into the t_index counter.
- t_init  in  T_W  initial t_index value.
- clear_err  in  1  clears sticky errors and drop_cnt.
- fader_start  out  1  single-cycle start pulse to the fader.
- fader_t_index  out  T_W  t_index presented to the fader; held stable while busy.
- fader_dv  in  1  fader dv_out.
- fader_zc_real  in  D_W  fader Zc_real.
- fader_zc_imag  in  D_W  fader Zc_imag.
- m_valid  out  1  result available.
- m_ready  in  1  downstream accept.
- m_t_index  out  T_W  t_index of the result.
- m_zc_real  out  D_W  result real part.
- m_zc_imag  out  D_W  result imaginary part.
- busy  out  1  operation outstanding (START or WAIT_DV).
- timeout_err  out  1  sticky.
- drop_cnt  out  8  saturating count of dropped ticks.
- stat_done  out  32  completed operations (optional feature).
- stat_max_lat  out  16  maximum start-to-dv latency (optional feature).

Behaviour:
- Reset values: all outputs 0; t_index 0; state IDLE; period counter 0.
- Tick timer:
  - While enable=1, the counter counts down from eff_period-1.
  - A tick is a single cycle when the count reaches 0; the counter reloads the same cycle.
  - While enable=0, the counter holds at eff_period-1.
  - A period change takes effect at the next reload.
- FSM states: IDLE, ARMED, START, WAIT_DV.
  - IDLE -> ARMED when enable=1.
  - ARMED -> START on a tick if the output register is free (m_valid=0, or m_valid&m_ready in the same cycle). Otherwise the tick is dropped and drop_cnt increments, saturating at 255.
  - ARMED -> IDLE when enable=0.
  - START: fader_start=1 for exactly one cycle, then WAIT_DV.
  - WAIT_DV: when fader_dv=1, capture {t_index, zc_real, zc_imag} into the output register, set m_valid next cycle, increment t_index (mod 2^T_W, wraps silently), then ARMED.
  - WAIT_DV timeout: the latency counter starts at 1 in the cycle after START. If it reaches TIMEOUT without dv: set timeout_err, do not increment t_index, go to ARMED.
- Ticks in START or WAIT_DV are dropped and counted.
- fader_dv outside WAIT_DV is ignored.
- Output register:
  - m_valid stays high until m_valid&m_ready.
  - Data is stable while m_valid=1.
  - Capture and accept in the same cycle are legal: new data, m_valid stays 1.
- load_t:
  - Honoured only in IDLE or ARMED; ignored while busy.
  - Takes priority over an increment in the same cycle.
- enable deassert mid-operation: the outstanding operation completes or times out, then IDLE. No new starts.
- clear_err: clears timeout_err and drop_cnt next cycle. It wins over a simultaneous set.
- fader_t_index = t_index register.
- Latency: tick to fader_start = 1 cycle; dv to m_valid = 1 cycle.

Optional Feature:
- Macro: FADER_CTRL_STATS_EN.
- Defined:
  - stat_done increments on each dv capture, wrapping.
  - stat_max_lat holds the maximum latency-counter value at dv, saturating at 16 bits.
  - Both are cleared by reset and clear_err.
- Undefined: both ports tied to 0; no counters synthesized.

Decomposition:
- Package fader_ctrl_pkg:
  - state enum typedef (IDLE, ARMED, START, WAIT_DV);
  - result struct typedef {t_index, zc_real, zc_imag};
  - constants DROP_CNT_W=8, STAT_LAT_W=16, MIN_PERIOD=2.
- Sub-module fader_ctrl_timer: period down-counter and tick generation (enable, period in; tick out).

Test Plan:
- period=1024, enable=1, fader model dv 300 cycles after start, m_ready=1 -> fader_start every 1024 cycles; m_t_index 0,1,2…; drop_cnt=0.
- m_ready=0 for 3 periods -> one result held stable; drop_cnt=2; no start until accept; then resumes.
- Fader never asserts dv, TIMEOUT=1023 -> timeout_err=1 at cycle 1023 after start; t_index unchanged; next tick restarts.
- load_t with t_init=2^25-1, two completions -> m_t_index 0x1FFFFFF then 0x0000000.
- period=0 -> ticks every 2 cycles; fader dv latency 5 -> drops counted, drop_cnt saturates at 255; clear_err -> 0.
- Assert reset during WAIT_DV -> all outputs 0 immediately; no start until enable and next tick. With STATS_EN: stat_max_lat equals the longest dv latency.
